// File: rtl/uart_tx_engine_pkg.sv
// Shared UART transmitter definitions: divisor width, frame size and the
// bit positions of the frame-format fields in the UART control register.
package uart_tx_engine_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int DATA_BITS = 8;

   // Frame-format field positions in the control register; the engine keeps
   // its latched copy of the format in the same layout.
   localparam int CTRL_PARITY_EN_BIT  = 0;
   localparam int CTRL_PARITY_ODD_BIT = 1;
   localparam int CTRL_STOP2_BIT      = 2;
   localparam int CTRL_W              = 3;

   function automatic logic frame_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick_o is high while the count is zero,
// so a load of N yields a bit period of N+1 clocks.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one byte from the TX FIFO per frame and shifts
// it out as start / 8 data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   input  logic                 cts_n,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_rddata,
   output logic                 fifo_rd_en,
   output logic                 txd,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   state_t                 state_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   data_q;
   logic [DIV_W-1:0]       div_q;
   logic [CTRL_W-1:0]      cfg_q;
   logic [2:0]             bit_cnt_q;
   logic                   stop_cnt_q;
   logic                   txd_q;
   logic                   busy_q;

   logic                   tick;
   logic                   in_bit;
   logic                   frame_end;
   logic                   baud_load;
   logic [DIV_W-1:0]       baud_load_val;

   assign in_bit = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);

   assign frame_end = (state_q == S_STOP) && tick &&
                      (!cfg_q[CTRL_STOP2_BIT] || stop_cnt_q);

   // FETCH loads the live divisor because div_q is only written on that same edge.
   assign baud_load     = (state_q == S_FETCH) || (in_bit && tick && !frame_end);
   assign baud_load_val = (state_q == S_FETCH) ? baud_div : div_q;

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk        (clk),
      .rst        (rst),
      .load_i     (baud_load),
      .load_val_i (baud_load_val),
      .tick_o     (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         data_q     <= '0;
         div_q      <= '0;
         cfg_q      <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (!fifo_empty && !cts_n) begin
                  state_q <= S_FETCH;
                  busy_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               shift_q                    <= fifo_rddata;
               data_q                     <= fifo_rddata;
               div_q                      <= baud_div;
               cfg_q[CTRL_PARITY_EN_BIT]  <= parity_en;
               cfg_q[CTRL_PARITY_ODD_BIT] <= parity_odd;
               cfg_q[CTRL_STOP2_BIT]      <= stop2;
               bit_cnt_q                  <= '0;
               stop_cnt_q                 <= 1'b0;
               txd_q                      <= 1'b0;
               state_q                    <= S_START;
            end
            S_START: begin
               if (tick) begin
                  txd_q   <= shift_q[0];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                     if (cfg_q[CTRL_PARITY_EN_BIT]) begin
                        txd_q   <= frame_parity(data_q, cfg_q[CTRL_PARITY_ODD_BIT]);
                        state_q <= S_PARITY;
                     end else begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                     end
                  end else begin
                     shift_q   <= shift_q >> 1;
                     txd_q     <= shift_q[1];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (tick) begin
                  txd_q   <= 1'b1;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (frame_end) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (tick) begin
                  stop_cnt_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en = (state_q == S_FETCH);
   assign txd        = txd_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a queue-based FIFO model feeds the engine and a
// frame-level reference expands each popped byte into per-clock txd samples.
module tb_uart_tx_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic        parity_en;
   logic        parity_odd;
   logic        stop2;
   logic        cts_n;
   logic        fifo_empty;
   logic [7:0]  fifo_rddata;
   logic        fifo_rd_en;
   logic        txd;
   logic        busy;

   uart_tx_engine dut (
      .clk         (clk),
      .rst         (rst),
      .baud_div    (baud_div),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .stop2       (stop2),
      .cts_n       (cts_n),
      .fifo_empty  (fifo_empty),
      .fifo_rddata (fifo_rddata),
      .fifo_rd_en  (fifo_rd_en),
      .txd         (txd),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // FIFO model: 16 entries, head byte appears on fifo_rddata one clock after
   // it becomes the head; pops take effect after the clock that ends FETCH.
   logic [7:0] fifo_q[$];
   logic [7:0] ref_q[$];
   logic [7:0] head_d;
   int         n_push = 0;
   int         n_rd   = 0;

   initial begin
      logic pend;
      fifo_empty  = 1'b1;
      fifo_rddata = 8'hEE;
      head_d      = 8'hEE;
      forever begin
         @(negedge clk);
         pend = fifo_rd_en;
         @(posedge clk);
         #2;
         if (pend === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
         fifo_rddata = head_d;
         head_d      = (fifo_q.size() > 0) ? fifo_q[0] : 8'hEE;
         fifo_empty  = (fifo_q.size() == 0);
      end
   end

   // Frame reference: per-clock expected txd samples of the frame in flight.
   logic exp_q[$];
   bit   fetch_exp  = 1'b0;
   bit   mon_en     = 1'b0;
   int   sample_idx = 0;
   int   frames     = 0;

   task automatic build_frame(input logic [7:0] b);
      logic bits[$];
      int   rep;
      rep = int'(baud_div) + 1;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (parity_en) bits.push_back((^b) ^ parity_odd);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      foreach (bits[i]) repeat (rep) exp_q.push_back(bits[i]);
      sample_idx = 0;
      frames++;
      $display("frame %0d: byte=%02h div=%0d par_en=%0b odd=%0b stop2=%0b clks=%0d",
               frames, b, baud_div, parity_en, parity_odd, stop2, exp_q.size());
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (fifo_rd_en === 1'b1) n_rd++;
         if (fetch_exp) begin
            chk("fetch_rd_en", fifo_rd_en, 1);
            chk("fetch_busy", busy, 1);
            chk("fetch_txd", txd, 1);
            chk("fetch_not_empty", fifo_empty, 0);
            fetch_exp = 1'b0;
            if (ref_q.size() == 0) chk("fetch_has_byte", 0, 1);
            else build_frame(ref_q.pop_front());
         end else if (exp_q.size() != 0) begin
            chk("frame_txd", txd, exp_q.pop_front());
            chk("frame_busy", busy, 1);
            chk("frame_rd_en", fifo_rd_en, 0);
            sample_idx++;
         end else begin
            chk("idle_txd", txd, 1);
            chk("idle_busy", busy, 0);
            chk("idle_rd_en", fifo_rd_en, 0);
            if (!fifo_empty && !cts_n && !rst) fetch_exp = 1'b1;
         end
         if (rst) begin
            exp_q.delete();
            fetch_exp  = 1'b0;
            sample_idx = 0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      step(1);
      if (fifo_q.size() < 16) begin
         fifo_q.push_back(b);
         ref_q.push_back(b);
         n_push++;
      end
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(posedge clk);
         if (fifo_q.size() == 0 && ref_q.size() == 0 && exp_q.size() == 0 && !fetch_exp)
            done = 1'b1;
      end
      chk(tag, done, 1);
      #1;
   endtask

   task automatic wait_sample(input string tag, input int n);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(posedge clk);
         if (exp_q.size() != 0 && sample_idx >= n) done = 1'b1;
      end
      chk(tag, done, 1);
      #1;
   endtask

   task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2);
      baud_div   = 16'(div);
      parity_en  = pe;
      parity_odd = po;
      stop2      = s2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      cts_n = 1'b0;
      set_cfg(3, 0, 0, 0);
      step(2);
      mon_en = 1'b1;
      chk("reset_txd", txd, 1);
      chk("reset_busy", busy, 0);
      chk("reset_rd_en", fifo_rd_en, 0);
      step(1);
      rst = 1'b0;
      step(2);

      // 8N1 at 4 clk/bit
      push(8'h55);
      wait_idle("t1_done");

      // parity even, odd, and two stop bits at 1 clk/bit
      set_cfg(0, 1, 0, 0);
      push(8'h07);
      wait_idle("t2_even_done");
      set_cfg(0, 1, 1, 0);
      push(8'h07);
      wait_idle("t2_odd_done");
      set_cfg(0, 1, 1, 1);
      push(8'h07);
      wait_idle("t2_stop2_done");

      // back-to-back frames
      set_cfg(1, 0, 0, 0);
      push(8'hA5);
      push(8'h3C);
      wait_idle("t3_done");

      // CTS held off, released, then raised mid-frame
      cts_n = 1'b1;
      push(8'h96);
      step(20);
      chk("t4_held_fifo", fifo_q.size(), 1);
      cts_n = 1'b0;
      wait_sample("t4_started", 5);
      cts_n = 1'b1;
      push(8'h81);
      step(40);
      chk("t4_second_held", fifo_q.size(), 1);
      cts_n = 1'b0;
      wait_idle("t4_done");

      // reset during data bit 4
      set_cfg(2, 0, 0, 0);
      push(8'hC3);
      wait_sample("t5_bit4", 16);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(30);
      chk("t5_no_pending", ref_q.size(), 0);

      // divisor change mid-frame applies to the next frame only
      set_cfg(3, 0, 0, 0);
      push(8'h5A);
      push(8'hF0);
      wait_sample("t6_midframe", 6);
      baud_div = 16'd9;
      wait_idle("t6_done");

      // randomized traffic with config and CTS changes at arbitrary times
      for (int it = 0; it < 25; it++) begin
         set_cfg($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) cts_n = ~cts_n;
         repeat ($urandom_range(1, 3)) begin
            if (fifo_q.size() < 14) push(8'($urandom));
         end
         step($urandom_range(0, 40));
      end
      cts_n = 1'b0;
      wait_idle("rand_done");

      chk("rd_en_pulses", n_rd, n_push);
      chk("ref_drained", ref_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
